// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// DIV_SIGNED_EN enables two's-complement operation in the files that import this package.
package seq_divider_pkg;

   localparam int DIV_N = 16;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Conditional two's-complement negation; callers truncate to their own width.
   function automatic logic [63:0] abs_val(input logic [63:0] v, input logic neg);
      if (neg) begin
         abs_val = ~v + 64'd1;
      end else begin
         abs_val = v;
      end
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// signed_i is present only when DIV_SIGNED_EN is defined.
interface seq_divider_if #(parameter int N = 16);

   logic         in_valid_i;
   logic         in_ready_o;
   logic [N-1:0] dividend_i;
   logic [N-1:0] divisor_i;
`ifdef DIV_SIGNED_EN
   logic         signed_i;
`endif
   logic         out_valid_o;
   logic         out_ready_i;
   logic [N-1:0] quotient_o;
   logic [N-1:0] remainder_o;
   logic         div_by_zero_o;

   modport master (
`ifdef DIV_SIGNED_EN
      output signed_i,
`endif
      output in_valid_i, dividend_i, divisor_i, out_ready_i,
      input  in_ready_o, out_valid_o, quotient_o, remainder_o, div_by_zero_o
   );

   modport slave (
`ifdef DIV_SIGNED_EN
      input  signed_i,
`endif
      input  in_valid_i, dividend_i, divisor_i, out_ready_i,
      output in_ready_o, out_valid_o, quotient_o, remainder_o, div_by_zero_o
   );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and shift the resulting quotient bit into dq.
module seq_divider_step #(parameter int N = 16) (
   input  logic [N-1:0] rem,
   input  logic [N-1:0] dq,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_next,
   output logic [N-1:0] dq_next
);

   logic [N:0] rem_sh_s;
   logic       ge_s;

   assign rem_sh_s = {rem, dq[N-1]};
   assign ge_s     = (rem_sh_s >= {1'b0, divisor});

   // The restored remainder is always below the divisor, so N bits hold it.
   always_comb begin
      dq_next = {dq[N-2:0], ge_s};
      if (ge_s) begin
         rem_next = N'(rem_sh_s - {1'b0, divisor});
      end else begin
         rem_next = rem_sh_s[N-1:0];
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN to add two's-complement operation selected by signed_i.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   localparam int CNT_W = $clog2(N);

   div_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] count_r;
   logic [N-1:0]     rem_r, dq_r, dvsr_r;
   logic [N-1:0]     rem_nxt_s, dq_nxt_s;
   logic [N-1:0]     q_r, r_r;
   logic             dbz_r, out_valid_r;
   logic             accept_s, zero_s, ovf_s, short_s;
   logic [N-1:0]     dq_load_s, dvsr_load_s, short_q_s, short_r_s, fix_q_s, fix_r_s;
`ifdef DIV_SIGNED_EN
   logic             neg_a_s, neg_b_s, neg_q_r, neg_r_r;
`endif

   seq_divider_step #(.N(N)) u_step (
      .rem      (rem_r),
      .dq       (dq_r),
      .divisor  (dvsr_r),
      .rem_next (rem_nxt_s),
      .dq_next  (dq_nxt_s)
   );

   // Operand conditioning at accept and sign fix-up of the final iteration.
   always_comb begin
      zero_s    = (bus.divisor_i == {N{1'b0}});
`ifdef DIV_SIGNED_EN
      ovf_s     = bus.signed_i & (bus.dividend_i == {1'b1, {(N-1){1'b0}}})
                  & (bus.divisor_i == {N{1'b1}});
      neg_a_s   = bus.signed_i & bus.dividend_i[N-1];
      neg_b_s   = bus.signed_i & bus.divisor_i[N-1];
      dq_load_s   = N'(abs_val(64'(bus.dividend_i), neg_a_s));
      dvsr_load_s = N'(abs_val(64'(bus.divisor_i), neg_b_s));
      fix_q_s   = N'(abs_val(64'(dq_nxt_s), neg_q_r));
      fix_r_s   = N'(abs_val(64'(rem_nxt_s), neg_r_r));
`else
      ovf_s       = 1'b0;
      dq_load_s   = bus.dividend_i;
      dvsr_load_s = bus.divisor_i;
      fix_q_s     = dq_nxt_s;
      fix_r_s     = rem_nxt_s;
`endif
      short_s   = zero_s | ovf_s;
      if (zero_s) begin
         short_q_s = {N{1'b1}};
         short_r_s = bus.dividend_i;
      end else begin
         short_q_s = bus.dividend_i;
         short_r_s = {N{1'b0}};
      end
   end

   // Next-state decode; zero-divisor and overflow skip straight to DONE.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         DIV_IDLE: begin
            if (bus.in_valid_i) begin
               accept_s    = 1'b1;
               state_nxt_s = short_s ? DIV_DONE : DIV_BUSY;
            end else begin
               state_nxt_s = DIV_IDLE;
            end
         end
         DIV_BUSY: begin
            if (count_r == {CNT_W{1'b0}}) begin
               state_nxt_s = DIV_DONE;
            end else begin
               state_nxt_s = DIV_BUSY;
            end
         end
         DIV_DONE: begin
            if (bus.out_ready_i) begin
               state_nxt_s = DIV_IDLE;
            end else begin
               state_nxt_s = DIV_DONE;
            end
         end
         default: state_nxt_s = DIV_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Iteration datapath and registered result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r     <= {CNT_W{1'b0}};
         rem_r       <= {N{1'b0}};
         dq_r        <= {N{1'b0}};
         dvsr_r      <= {N{1'b0}};
         q_r         <= {N{1'b0}};
         r_r         <= {N{1'b0}};
         dbz_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         count_r <= CNT_W'(N-1);
         rem_r   <= {N{1'b0}};
         dq_r    <= dq_load_s;
         dvsr_r  <= dvsr_load_s;
         if (short_s) begin
            q_r         <= short_q_s;
            r_r         <= short_r_s;
            dbz_r       <= zero_s;
            out_valid_r <= 1'b1;
         end
      end else if (state_r == DIV_BUSY) begin
         rem_r   <= rem_nxt_s;
         dq_r    <= dq_nxt_s;
         count_r <= count_r - CNT_W'(1);
         if (count_r == {CNT_W{1'b0}}) begin
            q_r         <= fix_q_s;
            r_r         <= fix_r_s;
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
         end
      end else if ((state_r == DIV_DONE) && bus.out_ready_i) begin
         out_valid_r <= 1'b0;
      end
   end

`ifdef DIV_SIGNED_EN
   // Result signs captured with the operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else if (accept_s) begin
         neg_q_r <= neg_a_s ^ neg_b_s;
         neg_r_r <= neg_a_s;
      end
   end
`endif

   assign bus.in_ready_o    = (state_r == DIV_IDLE);
   assign bus.out_valid_o   = out_valid_r;
   assign bus.quotient_o    = q_r;
   assign bus.remainder_o   = r_r;
   assign bus.div_by_zero_o = dbz_r;

endmodule
